duty_calc: RTL and testbench

//  Downstream consumer of the duty-cycle counter stage. Takes the raw high-time and

---
 rtl/duty_calc_pkg.sv | 17 +
 rtl/duty_calc_seq_divider.sv | 67 ++++++
 rtl/duty_calc.sv | 123 ++++++++++++
 tb/tb_duty_calc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/duty_calc_pkg.sv
// Shared definitions for the duty-cycle calculator: FSM encoding and default widths.
// NUM_W is the dividend width for the default configuration (count width plus scale width).
package duty_calc_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_SCALE   = 1000;
  localparam int DEF_SCALE_W = 10;
  localparam int NUM_W       = DEF_CNT_W + DEF_SCALE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/duty_calc_seq_divider.sv
// Generic restoring divider: one quotient bit per cycle, MSB first, NUM_W cycles after start.
// quo/done are combinational views of the step in flight so the caller can register on the last step.
module seq_divider #(
  parameter int NUM_W = 42,
  parameter int DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo,
  output logic             done,
  output logic             busy
);

  localparam int IDX_W = $clog2(NUM_W);

  logic [NUM_W-1:0] num_r;
  logic [DEN_W-1:0] den_r;
  logic [DEN_W-1:0] rem_r;
  logic [NUM_W-1:0] quo_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r;

  logic [DEN_W:0]   rem_sh;
  logic             ge;
  logic [DEN_W-1:0] rem_nx;
  logic [NUM_W-1:0] quo_nx;

  // The stored remainder is always below den, so only the shifted trial value needs the extra bit.
  always_comb begin
    rem_sh = {rem_r, num_r[idx_r]};
    ge     = (rem_sh >= {1'b0, den_r});
    rem_nx = ge ? DEN_W'(rem_sh - {1'b0, den_r}) : DEN_W'(rem_sh);
    quo_nx = quo_r;
    quo_nx[idx_r] = ge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_r  <= '0;
      den_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      idx_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      num_r  <= num;
      den_r  <= den;
      rem_r  <= '0;
      quo_r  <= '0;
      idx_r  <= IDX_W'(NUM_W - 1);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
      if (idx_r == '0) busy_r <= 1'b0;
      else             idx_r  <= idx_r - 1'b1;
    end
  end

  assign quo  = quo_nx;
  assign done = busy_r && (idx_r == '0);
  assign busy = busy_r;

endmodule

// File: rtl/duty_calc.sv
// Duty-cycle calculator: settles the asynchronous {high, T} counts, then computes high*SCALE/T.
// Each newly settled pair yields one duty_valid strobe; repeats of the last accepted pair are ignored.
module duty_calc
  import duty_calc_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SCALE    = DEF_SCALE,
  parameter int SCALE_W  = DEF_SCALE_W,
  parameter int STABLE_N = 3,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in_high,
  input  logic [CNT_W-1:0] in_T,
  output logic [OUT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             busy,
  output logic             err_zero
);

  localparam int DIV_W = CNT_W + SCALE_W;
  localparam int SC_W  = $clog2(STABLE_N + 1);

  state_t             state;
  logic [2*CNT_W-1:0] s0, s1, last;
  logic [SC_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]   s1_high, s1_t;
  logic               settled;
  logic               div_start, div_done, div_busy;
  logic [DIV_W-1:0]   div_num, div_quo;

  assign s1_high   = s1[2*CNT_W-1:CNT_W];
  assign s1_t      = s1[CNT_W-1:0];
  assign settled   = (stable_cnt == SC_W'(STABLE_N));
  assign div_num   = DIV_W'(s1_high) * DIV_W'(SCALE);
  assign div_start = (state == ST_LOAD) && (s1_t != '0) && (s1_high < s1_t);

  seq_divider #(
    .NUM_W (DIV_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (s1_t),
    .quo   (div_quo),
    .done  (div_done),
    .busy  (div_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      s0         <= '0;
      s1         <= '0;
      last       <= '0;
      stable_cnt <= '0;
      duty       <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
      err_zero   <= 1'b0;
    end else begin
      s0 <= {in_high, in_T};
      s1 <= s0;
      if (s0 != s1)     stable_cnt <= '0;
      else if (!settled) stable_cnt <= stable_cnt + 1'b1;

      duty_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (settled && (s1 != last)) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          last <= s1;
          if (s1_t == '0) begin
            duty       <= '0;
            period     <= '0;
            err_zero   <= 1'b1;
            duty_valid <= 1'b1;
            state      <= ST_DONE;
          end else if (s1_high >= s1_t) begin
            duty       <= OUT_W'(SCALE);
            period     <= s1_t;
            err_zero   <= 1'b0;
            duty_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          // Quotient cannot exceed SCALE here; the clamp only keeps the upper bits meaningful.
          if (div_done) begin
            duty       <= (div_quo > DIV_W'(SCALE)) ? OUT_W'(SCALE) : div_quo[OUT_W-1:0];
            period     <= last[CNT_W-1:0];
            err_zero   <= 1'b0;
            duty_valid <= 1'b1;
            state      <= ST_DONE;
          end else if (!div_busy) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_duty_calc.sv
// Directed bench for duty_calc: vector table for the main computation, hand sequences for
// input churn, repeat suppression and mid-division reset.
module tb_duty_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_high = '0;
  logic [31:0] in_T = '0;
  logic [15:0] duty;
  logic [31:0] period;
  logic        duty_valid, busy, err_zero;

  int total = 0;
  int bad   = 0;

  duty_calc dut (
    .clk        (clk),
    .rst        (rst),
    .in_high    (in_high),
    .in_T       (in_T),
    .duty       (duty),
    .period     (period),
    .duty_valid (duty_valid),
    .busy       (busy),
    .err_zero   (err_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] high;
    logic [31:0] t;
    int          exp_duty;
    int          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] h, input logic [31:0] t);
    @(posedge clk);
    #1;
    in_high = h;
    in_T    = t;
  endtask

  // n counts negedges after the posedge on which the inputs were applied.
  task automatic watch(input int win, output int nv, output int lat, output int bstart,
                       output int d, output longint p, output int e);
    nv = 0; lat = -1; bstart = -1; d = -1; p = -1; e = -1;
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      if (busy && bstart < 0) bstart = n;
      if (duty_valid) begin
        nv++;
        if (lat < 0) begin
          lat = n; d = int'(duty); p = longint'(period); e = int'(err_zero);
        end
      end
    end
  endtask

  initial begin
    int     nv, lat, bstart, d, e;
    longint p;

    // Long path: 2 sync flops + 3 stable counts + accept + LOAD + 42 DIV steps -> n=50; short path n=8.
    vecs[0]  = '{32'd250,        32'd1000,       250,  0, 50};
    vecs[1]  = '{32'd1,          32'd3,          333,  0, 50};
    vecs[2]  = '{32'd2,          32'd3,          666,  0, 50};
    vecs[3]  = '{32'd5,          32'd0,          0,    1, 8};
    vecs[4]  = '{32'd500,        32'd1000,       500,  0, 50};
    vecs[5]  = '{32'd1200,       32'd1000,       1000, 0, 8};
    vecs[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1000, 0, 8};
    vecs[7]  = '{32'd1,          32'd1000,       1,    0, 50};
    vecs[8]  = '{32'd999,        32'd1000,       999,  0, 50};
    vecs[9]  = '{32'd3,          32'd7,          428,  0, 50};
    vecs[10] = '{32'd1,          32'hFFFFFFFF,   0,    0, 50};
    vecs[11] = '{32'hFFFFFFFE,   32'hFFFFFFFF,   999,  0, 50};
    vecs[12] = '{32'd500,        32'd1000,       500,  0, 50};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", duty_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_zero, 0);
    rst = 1'b1;

    // All-zero inputs match the cleared last-accepted pair, so nothing should start.
    watch(12, nv, lat, bstart, d, p, e);
    chk("idle_zero_valids", nv, 0);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].high, vecs[i].t);
      watch(60, nv, lat, bstart, d, p, e);
      chk($sformatf("v%0d_count", i), nv, 1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_start", i), bstart, 7);
      chk($sformatf("v%0d_duty", i), d, vecs[i].exp_duty);
      chk($sformatf("v%0d_period", i), p, longint'(vecs[i].t));
      chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
    end

    // Inputs toggling every 2 cycles never settle long enough to be accepted.
    nv = 0;
    bstart = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k % 2 == 0) begin
        in_high = ((k / 2) % 2 == 0) ? 32'd100 : 32'd200;
        in_T    = 32'd1000;
      end
      @(negedge clk);
      if (duty_valid) nv++;
      if (busy) bstart++;
    end
    chk("toggle_valids", nv, 0);
    chk("toggle_busy_cycles", bstart, 0);

    // Returning to the last accepted pair must not trigger a recompute.
    apply(32'd500, 32'd1000);
    watch(60, nv, lat, bstart, d, p, e);
    chk("repeat_valids", nv, 0);
    chk("repeat_busy", bstart, -1);

    // Reset in the middle of a division aborts it.
    apply(32'd300, 32'd1000);
    nv = 0;
    for (int n = 0; n < 30 && !busy; n++) @(negedge clk);
    chk("abort_busy_seen", busy, 1);
    repeat (21) begin
      @(negedge clk);
      if (duty_valid) nv++;
    end
    chk("abort_pre_valids", nv, 0);
    rst = 1'b0;
    #1;
    chk("abort_duty", duty, 0);
    chk("abort_period", period, 0);
    chk("abort_valid", duty_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch(90, nv, lat, bstart, d, p, e);
    chk("abort_recompute_count", nv, 1);
    chk("abort_recompute_duty", d, 300);
    chk("abort_recompute_period", p, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
